// File: rtl/msrh_l1d_evict_queue.sv
// ============================================================================
// Module   : msrh_l1d_evict_queue
// Purpose  : N-entry L1D eviction queue with in-order writeback drain and
//            multi-port line search with youngest-hit data forwarding.
//            Optional same-line merging is enabled by MSRH_L1D_EVICT_MERGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrh_l1d_evict_queue #(
  parameter int unsigned ENTRIES      = 4,
  parameter int unsigned PADDR_W      = 56,
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned LINE_OFS     = $clog2(DATA_W/8),
  parameter int unsigned SEARCH_PORTS = 2
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_evict_valid,
  output logic                              o_evict_ready,
  input  logic [PADDR_W-1:0]                i_evict_paddr,
  input  logic [DATA_W-1:0]                 i_evict_data,
  output logic                              o_wb_valid,
  input  logic                              i_wb_ready,
  output logic [PADDR_W-1:0]                o_wb_paddr,
  output logic [DATA_W-1:0]                 o_wb_data,
  input  logic [SEARCH_PORTS-1:0]           i_search_valid,
  input  logic [SEARCH_PORTS*PADDR_W-1:0]   i_search_paddr,
  output logic [SEARCH_PORTS*ENTRIES-1:0]   o_search_hit_ways,
  output logic [SEARCH_PORTS-1:0]           o_search_hit,
  output logic [SEARCH_PORTS*DATA_W-1:0]    o_search_data,
  output logic [$clog2(ENTRIES):0]          o_count,
  output logic                              o_empty
);

  localparam int unsigned c_PTR_W  = $clog2(ENTRIES);
  localparam int unsigned c_CNT_W  = c_PTR_W + 1;
  localparam int unsigned c_LINE_W = PADDR_W - LINE_OFS;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(ENTRIES);

  typedef logic [c_LINE_W-1:0] line_t;

  logic [ENTRIES-1:0] valid_q, valid_d;
  line_t              line_q [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  line_t              w_evict_line;
  logic               w_full;
  logic               w_deq;
  logic               w_enq;
  logic               w_alloc;
  logic               w_merge;
  logic [c_PTR_W-1:0] w_merge_idx;

  assign w_evict_line = i_evict_paddr[PADDR_W-1:LINE_OFS];
  assign w_full       = (count_q == c_FULL);
  assign w_deq        = valid_q[head_q] && i_wb_ready;

`ifdef MSRH_L1D_EVICT_MERGE_EN
  // The head leaving this cycle is not a merge target; the request allocates instead.
  always_comb begin
    w_merge     = 1'b0;
    w_merge_idx = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (valid_q[e] && (line_q[e] == w_evict_line) &&
          !(w_deq && (head_q == c_PTR_W'(e)))) begin
        w_merge     = 1'b1;
        w_merge_idx = c_PTR_W'(e);
      end
    end
  end
`else
  assign w_merge     = 1'b0;
  assign w_merge_idx = '0;
`endif

  assign o_evict_ready = !w_full || w_merge;
  assign w_enq         = i_evict_valid && o_evict_ready;
  assign w_alloc       = w_enq && !w_merge;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (w_alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({w_alloc, w_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_alloc) begin
      line_q[tail_q] <= w_evict_line;
      data_q[tail_q] <= i_evict_data;
    end else if (w_enq && w_merge) begin
      data_q[w_merge_idx] <= i_evict_data;
    end
  end

  assign o_wb_valid = valid_q[head_q];
  assign o_wb_paddr = {line_q[head_q], {LINE_OFS{1'b0}}};
  assign o_wb_data  = data_q[head_q];
  assign o_count    = count_q;
  assign o_empty    = (count_q == '0);

  generate
    for (genvar gp = 0; gp < SEARCH_PORTS; gp++) begin : g_search
      line_t              w_line;
      logic [ENTRIES-1:0] w_hits;
      logic [DATA_W-1:0]  w_data;
      logic [c_PTR_W-1:0] w_idx;

      assign w_line = i_search_paddr[gp*PADDR_W+LINE_OFS +: c_LINE_W];

      always_comb begin
        w_hits = '0;
        for (int e = 0; e < ENTRIES; e++) begin
          w_hits[e] = i_search_valid[gp] && valid_q[e] && (line_q[e] == w_line);
        end
      end

      // Walk oldest to youngest so the hit nearest tail-1 is written last.
      always_comb begin
        w_data = '0;
        w_idx  = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
          w_idx = tail_q - c_PTR_W'(k + 1);
          if (w_hits[w_idx]) begin
            w_data = data_q[w_idx];
          end
        end
      end

      assign o_search_hit_ways[gp*ENTRIES +: ENTRIES] = w_hits;
      assign o_search_hit[gp]                         = |w_hits;
      assign o_search_data[gp*DATA_W +: DATA_W]       = w_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_msrh_l1d_evict_queue.sv
// ============================================================================
// Module   : tb_msrh_l1d_evict_queue
// Purpose  : Directed self-checking bench for msrh_l1d_evict_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msrh_l1d_evict_queue;

  localparam int ENTRIES = 4;
  localparam int PADDR_W = 56;
  localparam int DATA_W  = 512;
  localparam int SP      = 2;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic                    i_evict_valid;
  logic                    o_evict_ready;
  logic [PADDR_W-1:0]      i_evict_paddr;
  logic [DATA_W-1:0]       i_evict_data;
  logic                    o_wb_valid;
  logic                    i_wb_ready;
  logic [PADDR_W-1:0]      o_wb_paddr;
  logic [DATA_W-1:0]       o_wb_data;
  logic [SP-1:0]           i_search_valid;
  logic [SP*PADDR_W-1:0]   i_search_paddr;
  logic [SP*ENTRIES-1:0]   o_search_hit_ways;
  logic [SP-1:0]           o_search_hit;
  logic [SP*DATA_W-1:0]    o_search_data;
  logic [2:0]              o_count;
  logic                    o_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  msrh_l1d_evict_queue #(
    .ENTRIES(ENTRIES), .PADDR_W(PADDR_W), .DATA_W(DATA_W), .SEARCH_PORTS(SP)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_evict_valid(i_evict_valid), .o_evict_ready(o_evict_ready),
    .i_evict_paddr(i_evict_paddr), .i_evict_data(i_evict_data),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_paddr(o_wb_paddr), .o_wb_data(o_wb_data),
    .i_search_valid(i_search_valid), .i_search_paddr(i_search_paddr),
    .o_search_hit_ways(o_search_hit_ways), .o_search_hit(o_search_hit),
    .o_search_data(o_search_data), .o_count(o_count), .o_empty(o_empty)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [31:0] s);
    return {16{s}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic enq(input logic [PADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i_evict_valid = 1'b1;
    i_evict_paddr = a;
    i_evict_data  = d;
    tick();
    i_evict_valid = 1'b0;
  endtask

  task automatic search(input logic v0, input logic [PADDR_W-1:0] a0,
                        input logic v1, input logic [PADDR_W-1:0] a1);
    i_search_valid = {v1, v0};
    i_search_paddr = {a1, a0};
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  always @(negedge i_clk) begin
    if (!i_reset && o_count > 3'(ENTRIES)) begin
      n_errors++;
      $display("FAIL count_bound: got %0d, expected <= %0d", o_count, ENTRIES);
    end
  end

  initial begin
    i_reset = 1'b1; i_evict_valid = 1'b0; i_evict_paddr = '0; i_evict_data = '0;
    i_wb_ready = 1'b0; i_search_valid = '0; i_search_paddr = '0;
    tick(); tick();
    i_reset = 1'b0;
    tick();

    // Reset state
    search(1'b1, 56'h1000, 1'b1, 56'h0);
    check("rst_wb_valid", 512'(o_wb_valid), 512'(0));
    check("rst_empty", 512'(o_empty), 512'(1));
    check("rst_count", 512'(o_count), 512'(0));
    check("rst_hit", 512'(o_search_hit), 512'(0));

    // Fill with writeback stalled
    for (int i = 0; i < 4; i++) enq(56'h1000 + 56'(i * 'h40), dat(32'h1000 + 32'(i)));
    check("fill_count", 512'(o_count), 512'(4));
    i_evict_valid = 1'b1; i_evict_paddr = 56'h9000; i_evict_data = dat(32'hDEAD);
    #1;
    check("fill_ready", 512'(o_evict_ready), 512'(0));
    tick();
    i_evict_valid = 1'b0;
    check("full_count_hold", 512'(o_count), 512'(4));
    check("hold_paddr", 512'(o_wb_paddr), 512'(56'h1000));
    check("hold_data", o_wb_data, dat(32'h1000));
    check("hold_valid", 512'(o_wb_valid), 512'(1));

    // Drain in order
    i_wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_paddr%0d", i), 512'(o_wb_paddr), 512'(56'h1000 + 56'(i * 'h40)));
      tick();
    end
    i_wb_ready = 1'b0;
    check("drain_empty", 512'(o_empty), 512'(1));
    check("drain_wb_valid", 512'(o_wb_valid), 512'(0));

    // Simultaneous enqueue/dequeue at count=1, wrapping pointers
    enq(56'h1100, dat(32'h1100));
    for (int i = 0; i < 5; i++) begin
      i_evict_valid = 1'b1; i_evict_paddr = 56'h1140 + 56'(i * 'h40); i_wb_ready = 1'b1;
      tick();
      check($sformatf("sim_count%0d", i), 512'(o_count), 512'(1));
      check($sformatf("sim_paddr%0d", i), 512'(o_wb_paddr), 512'(56'h1140 + 56'(i * 'h40)));
    end
    i_evict_valid = 1'b0; i_wb_ready = 1'b0;

    // Asynchronous reset mid-drain
    enq(56'h1280, dat(32'h1280));
    enq(56'h12C0, dat(32'h12C0));
    check("pre_rst_count", 512'(o_count), 512'(3));
    i_wb_ready = 1'b1;
    tick();
    #1;
    i_reset = 1'b1;
    #1;
    check("arst_wb_valid", 512'(o_wb_valid), 512'(0));
    check("arst_count", 512'(o_count), 512'(0));
    check("arst_empty", 512'(o_empty), 512'(1));
    search(1'b1, 56'h1280, 1'b1, 56'h12C0);
    check("arst_hit", 512'(o_search_hit), 512'(0));
    i_reset = 1'b0; i_wb_ready = 1'b0;
    tick();

    // Search with offset bits ignored
    enq(56'h2000, dat(32'hAAAA0000));
    enq(56'h2040, dat(32'hBBBB0000));
    search(1'b1, 56'h2010, 1'b1, 56'h3000);
    check("s_ways0", 512'(o_search_hit_ways[3:0]), 512'(4'b0001));
    check("s_data0", o_search_data[DATA_W-1:0], dat(32'hAAAA0000));
    check("s_hit1", 512'(o_search_hit[1]), 512'(0));
    check("s_ways1", 512'(o_search_hit_ways[7:4]), 512'(0));
    check("s_data1", o_search_data[2*DATA_W-1:DATA_W], 512'(0));
    search(1'b1, 56'h2010, 1'b1, 56'h2040);
    check("s_ways1b", 512'(o_search_hit_ways[7:4]), 512'(4'b0010));
    check("s_data1b", o_search_data[2*DATA_W-1:DATA_W], dat(32'hBBBB0000));
    i_evict_valid = 1'b1; i_evict_paddr = 56'h2080; i_evict_data = dat(32'hCCCC0000);
    i_wb_ready = 1'b1;
    search(1'b1, 56'h2000, 1'b1, 56'h2080);
    check("s_deq_hit", 512'(o_search_hit[0]), 512'(1));
    check("s_enq_nohit", 512'(o_search_hit[1]), 512'(0));
    tick();
    i_evict_valid = 1'b0; i_wb_ready = 1'b0;
    #1;
    check("s_after_enq", 512'(o_search_hit_ways[7:4]), 512'(4'b0100));
    check("s_after_deq", 512'(o_search_hit[0]), 512'(0));

    // Duplicate line handling
    do_reset();
    enq(56'h2000, dat(32'hAAAA0001));
    enq(56'h2000, dat(32'hBBBB0001));
    search(1'b1, 56'h2000, 1'b0, 56'h0);
`ifdef MSRH_L1D_EVICT_MERGE_EN
    check("dup_count", 512'(o_count), 512'(1));
    check("dup_ways", 512'(o_search_hit_ways[3:0]), 512'(4'b0001));
`else
    check("dup_count", 512'(o_count), 512'(2));
    check("dup_ways", 512'(o_search_hit_ways[3:0]), 512'(4'b0011));
`endif
    check("dup_data", o_search_data[DATA_W-1:0], dat(32'hBBBB0001));

    // Full queue with a line matching a non-head entry
    do_reset();
    for (int i = 0; i < 4; i++) enq(56'h4000 + 56'(i * 'h40), dat(32'h4000 + 32'(i)));
    i_evict_valid = 1'b1; i_evict_paddr = 56'h4080; i_evict_data = dat(32'h5A5A5A5A);
    #1;
`ifdef MSRH_L1D_EVICT_MERGE_EN
    check("full_merge_ready", 512'(o_evict_ready), 512'(1));
`else
    check("full_merge_ready", 512'(o_evict_ready), 512'(0));
`endif
    tick();
    i_evict_valid = 1'b0;
    check("full_merge_count", 512'(o_count), 512'(4));
    search(1'b1, 56'h4080, 1'b0, 56'h0);
`ifdef MSRH_L1D_EVICT_MERGE_EN
    check("full_merge_data", o_search_data[DATA_W-1:0], dat(32'h5A5A5A5A));
`else
    check("full_merge_data", o_search_data[DATA_W-1:0], dat(32'h4002));
`endif
    check("full_head_paddr", 512'(o_wb_paddr), 512'(56'h4000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/msrh_l1d_evict_queue.md
Name: msrh_l1d_evict_queue

Overview:
- Parametrised N-entry eviction queue between the L1D replace path and the L2/bus writeback channel.
- Evictions arrive on a valid/ready slave port and drain in order on a valid/ready master port.
- Up to SEARCH_PORTS parallel line-address searches return a hit bitmap and forwarded line data, so that LRQ/STQ refills never read stale memory.
- Next generation of the single-channel evict/search interface pair: adds depth, multi-port search, data forwarding and optional same-line merging.

Parameters:
ENTRIES, 4, queue depth; power of two, 2..16
PADDR_W, riscv_pkg::PADDR_W, physical address width
DATA_W, msrh_conf_pkg::DCACHE_DATA_W, cache line width in bits
LINE_OFS, $clog2(DATA_W/8), line offset bits ignored in address compares
SEARCH_PORTS, 2, number of independent search ports

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_evict_valid  in  1  eviction request valid
o_evict_ready  out  1  queue can accept or merge this cycle
i_evict_paddr  in  PADDR_W  evicted line address
i_evict_data  in  DATA_W  evicted line data
o_wb_valid  out  1  head entry valid toward L2
i_wb_ready  in  1  L2 accepts head
o_wb_paddr  out  PADDR_W  head line address, offset bits forced to 0
o_wb_data  out  DATA_W  head line data
i_search_valid  in  SEARCH_PORTS  search request per port
i_search_paddr  in  SEARCH_PORTS*PADDR_W  search address per port
o_search_hit_ways  out  SEARCH_PORTS*ENTRIES  per-port entry hit bitmap
o_search_hit  out  SEARCH_PORTS  OR of the port's bitmap
o_search_data  out  SEARCH_PORTS*DATA_W  data of the youngest hitting entry
o_count  out  $clog2(ENTRIES)+1  occupied entries
o_empty  out  1  count == 0

Behaviour:
- Interface fixed: single clock i_clk; reset i_reset is asynchronous and active-high.
- Reset values:
  - head, tail and count are 0; all entry valid bits are 0.
  - o_wb_valid=0, o_empty=1, o_count=0; all search hits 0.
  - Data and address storage is not reset.
- Storage:
  - Circular buffer with head/tail pointers of $clog2(ENTRIES) bits, wrapping modulo ENTRIES.
  - Each entry holds valid, paddr line and data.
- Line address: paddr[PADDR_W-1:LINE_OFS] in all compares.
- Enqueue:
  - Fires when i_evict_valid && o_evict_ready.
  - Allocate mode writes the tail entry, sets its valid and increments tail.
  - Merge mode applies when compiled in (see Optional Feature).
  - Visible on o_wb and search from the next cycle. Latency is 1 cycle; no enqueue-to-output bypass.
- Dequeue:
  - o_wb_valid = entry[head].valid.
  - On o_wb_valid && i_wb_ready, clear entry[head].valid and increment head.
  - o_wb_* is held stable while o_wb_valid && !i_wb_ready.
- Full:
  - Allocate is not permitted when count == ENTRIES, even if a dequeue fires the same cycle.
  - This avoids a combinational path from i_wb_ready to o_evict_ready.
- Empty: o_wb_valid=0. A simultaneous enqueue shows o_wb_valid=1 next cycle.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Count: +1 on allocate, -1 on dequeue, net 0 when both fire. Merges do not change count.
- Search:
  - Purely combinational against the current registered entries.
  - Bit e is set when i_search_valid[p], entry[e].valid and the line addresses are equal.
  - An entry being dequeued this cycle still reports a hit.
  - An entry being enqueued this cycle does not hit.
  - o_search_data selects the youngest hit, i.e. closest to tail-1 going backward with wrap-around.
  - o_search_data is 0 when there is no hit.
- Overflow and underflow cannot occur by construction. A bench assertion flags count > ENTRIES.
- Reset mid-operation: all entries are dropped immediately (asynchronous). o_wb_valid falls in the same cycle.

Optional Feature:
- Macro: MSRH_L1D_EVICT_MERGE_EN.
- Defined:
  - If an incoming eviction's line matches a valid entry other than head-being-dequeued-this-cycle, that entry's data is overwritten in place and no allocation occurs.
  - o_evict_ready = (count<ENTRIES) || merge_match.
  - If the only match is the head dequeuing this cycle, the request allocates normally, subject to the full rule.
  - Invariant: at most one bit per search bitmap.
- Undefined:
  - Every enqueue allocates; duplicate lines may coexist.
  - o_evict_ready = (count<ENTRIES).
  - The youngest-hit data select resolves duplicates.

Test Plan:
- Reset then enqueue lines 0x1000,0x1040,0x1080,0x10C0 with i_wb_ready=0 -> o_count=4, o_evict_ready=0, o_wb_paddr=0x1000 held stable.
- Same state, raise i_wb_ready for 4 cycles -> paddrs drained in order 0x1000..0x10C0, o_empty=1 after the 4th. Then enqueue and dequeue in the same cycle at count=1 -> count stays 1, and pointers wrap correctly after index 3.
- Entries 0x2000,0x2040; port0 searches 0x2010 and port1 searches 0x3000 -> hit_ways0=4'b0001 with data0=entry0 data, hit1=0, data1=0.
- Without merge: enqueue 0x2000 with data A, then 0x2000 with data B -> count=2, search bitmap 4'b0011, search data=B. With MERGE_EN: count=1, data=B, bitmap 4'b0001.
- With MERGE_EN, full queue, enqueue a line matching a non-head entry -> o_evict_ready=1, count stays 4, entry data updated.
- Assert i_reset asynchronously with 3 entries mid-drain -> o_wb_valid=0 and o_count=0 in the same cycle, no search hits afterwards.
